// File: rtl/mac_pkg.sv
// Shared constants and helpers for the MAC adder-sharing logic.
//   MAC_ADDER_LATENCY : cycles from adder valid-in to adder valid-out
//   MAC_DATA_W        : default operand/sum width
//   mac_id_width()    : requester-ID width, never less than one bit
package mac_pkg;

    localparam int MAC_ADDER_LATENCY = 7;
    localparam int MAC_DATA_W        = 32;

    // $clog2(1) and $clog2(2) would give 0 and 1; an ID field must hold at least one bit.
    function automatic int mac_id_width(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/mac_rr_arbiter.sv
// Round-robin arbiter.
//   i_clk, i_rst : clock and synchronous active-high reset
//   i_req        : request vector
//   i_accept     : a granted request was taken this cycle; advances the pointer
//   o_grant      : one-hot (or zero) grant, forced to zero during reset
//   o_grant_id   : binary index of the granted requester
module mac_rr_arbiter
    import mac_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = mac_id_width(NUM_REQ)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_accept,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_grant_id
);

    logic [ID_W-1:0]    r_ptr;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grant_id;
    logic               w_found;

    // Scan from the pointer upward with wrap-around; the first request seen wins.
    always_comb begin
        int idx;
        w_grant    = '0;
        w_grant_id = '0;
        w_found    = 1'b0;
        idx        = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(r_ptr) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!w_found && i_req[idx]) begin
                w_found        = 1'b1;
                w_grant[idx]   = 1'b1;
                w_grant_id     = ID_W'(idx);
            end
        end
        // No requester may see ready while the datapath is being cleared.
        if (i_rst) begin
            w_grant = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (i_accept) begin
            r_ptr <= (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_id + 1'b1;
        end
    end

    assign o_grant    = w_grant;
    assign o_grant_id = w_grant_id;

endmodule

// File: rtl/mac_adder_arbiter.sv
// Shares one fixed-latency pipelined adder among NUM_REQ requesters.
// Winning operands are registered into the adder, the requester ID rides a
// tag pipe matched to the adder latency, and each sum is returned to its
// owner as a one-cycle pulse on a shared response bus.
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_req_valid/a/b         : per-requester operand valid and packed operands
//   o_req_ready             : one-hot grant (transfer on valid & ready)
//   o_adder_a/b/valid       : registered issue to the adder
//   i_adder_val/valid       : adder result and strobe
//   o_rsp_valid, o_rsp_val  : one-hot response strobe and shared sum
//   o_busy                  : any operation in flight
//   o_err                   : sticky adder/tag-pipe valid disagreement
module mac_adder_arbiter
    import mac_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int DATA_W        = MAC_DATA_W,
    parameter int ADDER_LATENCY = MAC_ADDER_LATENCY
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_a,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_b,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic [DATA_W-1:0]         o_adder_a,
    output logic [DATA_W-1:0]         o_adder_b,
    output logic                      o_adder_valid,
    input  logic [DATA_W-1:0]         i_adder_val,
    input  logic                      i_adder_valid,
    output logic [NUM_REQ-1:0]        o_rsp_valid,
    output logic [DATA_W-1:0]         o_rsp_val,
    output logic                      o_busy,
    output logic                      o_err
);

    localparam int ID_W = mac_id_width(NUM_REQ);

    logic [DATA_W-1:0]        w_req_a [NUM_REQ];
    logic [DATA_W-1:0]        w_req_b [NUM_REQ];
    logic [NUM_REQ-1:0]       w_grant;
    logic [ID_W-1:0]          w_grant_id;
    logic                     w_accept;

    logic                     r_adder_valid;
    logic [DATA_W-1:0]        r_adder_a;
    logic [DATA_W-1:0]        r_adder_b;
    logic [ID_W-1:0]          r_issue_id;

    logic [ADDER_LATENCY-1:0] r_tag_valid;
    logic [ID_W-1:0]          r_tag_id [ADDER_LATENCY];
    logic                     w_last_valid;
    logic [ID_W-1:0]          w_last_id;

    logic [NUM_REQ-1:0]       r_rsp_valid;
    logic [DATA_W-1:0]        r_rsp_val;
    logic                     r_err;
    logic [NUM_REQ-1:0]       w_rsp_onehot;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_req_a[gi] = i_req_a[gi*DATA_W +: DATA_W];
            assign w_req_b[gi] = i_req_b[gi*DATA_W +: DATA_W];
        end
    endgenerate

    mac_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_req      (i_req_valid),
        .i_accept   (w_accept),
        .o_grant    (w_grant),
        .o_grant_id (w_grant_id)
    );

    // The grant only ever names a valid requester, so any grant is a transfer.
    assign w_accept    = |(w_grant & i_req_valid);
    assign o_req_ready = w_grant;

    // Issue register: operands hold when nothing is issued.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_adder_valid <= 1'b0;
            r_adder_a     <= '0;
            r_adder_b     <= '0;
            r_issue_id    <= '0;
        end else begin
            r_adder_valid <= w_accept;
            if (w_accept) begin
                r_adder_a  <= w_req_a[w_grant_id];
                r_adder_b  <= w_req_b[w_grant_id];
                r_issue_id <= w_grant_id;
            end
        end
    end

    // Tag pipe: stage 0 captures what the adder captures on the same edge,
    // so the last stage is presented alongside the adder's valid-out.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tag_valid <= '0;
            for (int i = 0; i < ADDER_LATENCY; i++) begin
                r_tag_id[i] <= '0;
            end
        end else begin
            r_tag_valid[0] <= r_adder_valid;
            r_tag_id[0]    <= r_issue_id;
            for (int i = 1; i < ADDER_LATENCY; i++) begin
                r_tag_valid[i] <= r_tag_valid[i-1];
                r_tag_id[i]    <= r_tag_id[i-1];
            end
        end
    end

    assign w_last_valid = r_tag_valid[ADDER_LATENCY-1];
    assign w_last_id    = r_tag_id[ADDER_LATENCY-1];
    assign w_rsp_onehot = NUM_REQ'(1) << w_last_id;

    // Response steering. A result the tag pipe does not expect is dropped and
    // flagged rather than delivered to a guessed owner.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rsp_valid <= '0;
            r_rsp_val   <= '0;
            r_err       <= 1'b0;
        end else begin
            r_rsp_valid <= '0;
            if (i_adder_valid && w_last_valid) begin
                r_rsp_valid <= w_rsp_onehot;
                r_rsp_val   <= i_adder_val;
            end
            if (i_adder_valid != w_last_valid) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_adder_a     = r_adder_a;
    assign o_adder_b     = r_adder_b;
    assign o_adder_valid = r_adder_valid;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_val     = r_rsp_val;
    assign o_err         = r_err;
    assign o_busy        = r_adder_valid | (|r_tag_valid) | (|r_rsp_valid);

endmodule

// File: tb/tb_mac_adder_arbiter.sv
module tb_mac_adder_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N*DW-1:0] req_a;
    logic [N*DW-1:0] req_b;
    logic [N-1:0]  req_ready;
    logic [DW-1:0] adder_a;
    logic [DW-1:0] adder_b;
    logic          adder_valid;
    logic [DW-1:0] adder_val;
    logic          adder_valid_in;
    logic [N-1:0]  rsp_valid;
    logic [DW-1:0] rsp_val;
    logic          busy;
    logic          err;
    logic          inj;

    int n_cmp = 0;
    int n_bad = 0;

    mac_adder_arbiter dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req_valid   (req_valid),
        .i_req_a       (req_a),
        .i_req_b       (req_b),
        .o_req_ready   (req_ready),
        .o_adder_a     (adder_a),
        .o_adder_b     (adder_b),
        .o_adder_valid (adder_valid),
        .i_adder_val   (adder_val),
        .i_adder_valid (adder_valid_in),
        .o_rsp_valid   (rsp_valid),
        .o_rsp_val     (rsp_val),
        .o_busy        (busy),
        .o_err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 7-cycle adder sharing the reset; inj forces a spurious strobe.
    logic [6:0]    m_v;
    logic [DW-1:0] m_s [7];
    always @(posedge clk) begin
        if (rst) begin
            m_v <= '0;
        end else begin
            m_v    <= {m_v[5:0], adder_valid};
            m_s[0] <= adder_a + adder_b;
            for (int i = 1; i < 7; i++) m_s[i] <= m_s[i-1];
        end
    end
    assign adder_valid_in = m_v[6] | inj;
    assign adder_val      = m_s[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_a[k*DW +: DW] = a;
        req_b[k*DW +: DW] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            req_valid = N'($urandom_range(1, 15));
            req_a = {$urandom, $urandom, $urandom, $urandom};
            req_b = {$urandom, $urandom, $urandom, $urandom};
            step();
            n_cmp++;
            if (req_ready !== 4'b0000) begin
                n_bad++; $display("FAIL reset_ready: got %b expected 0000", req_ready);
            end
            n_cmp++;
            if ({adder_valid, rsp_valid, busy, err} !== 7'b0) begin
                n_bad++; $display("FAIL reset_flags: got v=%b rsp=%b busy=%b err=%b expected all 0",
                                  adder_valid, rsp_valid, busy, err);
            end
            n_cmp++;
            if ({adder_a, adder_b, rsp_val} !== 96'b0) begin
                n_bad++; $display("FAIL reset_data: got a=%h b=%h rsp=%h expected 0", adder_a, adder_b, rsp_val);
            end
        end
        req_valid = '0;
        rst = 1'b0;
        $display("reset: 3 cycles checked");
    endtask

    task automatic test_single();
        set_op(1, 32'd5, 32'd7);
        req_valid = 4'b0010;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0010) begin
            n_bad++; $display("FAIL single_ready: got %b expected 0010", req_ready);
        end
        step();
        req_valid = '0;
        n_cmp++;
        if ({adder_valid, adder_a, adder_b} !== {1'b1, 32'd5, 32'd7}) begin
            n_bad++; $display("FAIL single_issue: got v=%b a=%h b=%h expected v=1 a=5 b=7", adder_valid, adder_a, adder_b);
        end
        for (int c = 2; c <= 8; c++) begin
            step();
            n_cmp++;
            if (rsp_valid !== 4'b0000) begin
                n_bad++; $display("FAIL single_early_rsp: cycle +%0d got %b expected 0000", c, rsp_valid);
            end
        end
        step();
        n_cmp++;
        if (rsp_valid !== 4'b0010 || rsp_val !== 32'd12) begin
            n_bad++; $display("FAIL single_rsp: got %b/%0d expected 0010/12", rsp_valid, rsp_val);
        end
        $display("single: req1 5+7 -> rsp %b val %0d", rsp_valid, rsp_val);
        step();
        n_cmp++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
            n_bad++; $display("FAIL single_idle: got rsp=%b busy=%b expected 0000/0", rsp_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_val;
        int j;
        for (int k = 0; k < 31; k++) begin
            if (k < 20) begin
                set_op(1, DW'(3*k + 1), 32'd1000);
                req_valid = 4'b0010;
            end else begin
                req_valid = '0;
            end
            #1;
            if (k < 20) begin
                n_cmp++;
                if (req_ready !== 4'b0010) begin
                    n_bad++; $display("FAIL b2b_ready: op %0d got %b expected 0010", k, req_ready);
                end
            end
            step();
            j = k - 8;
            if (j >= 0 && j < 20) begin
                exp_val = DW'(3*j + 1001);
                n_cmp++;
                if (rsp_valid !== 4'b0010 || rsp_val !== exp_val) begin
                    n_bad++; $display("FAIL b2b_rsp: op %0d got %b/%0d expected 0010/%0d", j, rsp_valid, rsp_val, exp_val);
                end
                $display("b2b: op %0d rsp %b val %0d", j, rsp_valid, rsp_val);
            end else begin
                n_cmp++;
                if (rsp_valid !== 4'b0000) begin
                    n_bad++; $display("FAIL b2b_idle: step %0d got %b expected 0000", k, rsp_valid);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0]  exp_oh;
        logic [DW-1:0] exp_val;
        int j;
        do_reset();
        for (int k = 0; k < N; k++) set_op(k, DW'(k), 32'd100);
        for (int m = 0; m < 20; m++) begin
            req_valid = (m < 8) ? 4'b1111 : 4'b0000;
            #1;
            if (m < 8) begin
                exp_oh = 4'b0001 << (m % 4);
                n_cmp++;
                if (req_ready !== exp_oh) begin
                    n_bad++; $display("FAIL rr_grant: slot %0d got %b expected %b", m, req_ready, exp_oh);
                end
            end
            step();
            j = m - 8;
            if (j >= 0 && j < 8) begin
                exp_oh  = 4'b0001 << (j % 4);
                exp_val = DW'(100 + (j % 4));
                n_cmp++;
                if (rsp_valid !== exp_oh || rsp_val !== exp_val) begin
                    n_bad++; $display("FAIL rr_rsp: op %0d got %b/%0d expected %b/%0d", j, rsp_valid, rsp_val, exp_oh, exp_val);
                end
                $display("rr: op %0d rsp %b val %0d", j, rsp_valid, rsp_val);
            end
        end
    endtask

    task automatic test_wrap_carry();
        logic [N-1:0]  exp_oh;
        logic [DW-1:0] exp_val;
        int j;
        do_reset();
        set_op(2, 32'd2, 32'd3);
        set_op(3, 32'hFFFF_FFFF, 32'd1);
        set_op(0, 32'h7FFF_FFFF, 32'd1);
        for (int m = 0; m < 14; m++) begin
            case (m)
                0:       begin req_valid = 4'b0100; exp_oh = 4'b0100; end
                1:       begin req_valid = 4'b1001; exp_oh = 4'b1000; end
                2:       begin req_valid = 4'b0001; exp_oh = 4'b0001; end
                default: begin req_valid = 4'b0000; exp_oh = 4'b0000; end
            endcase
            #1;
            n_cmp++;
            if (req_ready !== exp_oh) begin
                n_bad++; $display("FAIL wrap_grant: slot %0d got %b expected %b", m, req_ready, exp_oh);
            end
            step();
            j = m - 8;
            case (j)
                0:       begin exp_oh = 4'b0100; exp_val = 32'd5; end
                1:       begin exp_oh = 4'b1000; exp_val = 32'h0000_0000; end
                2:       begin exp_oh = 4'b0001; exp_val = 32'h8000_0000; end
                default: begin exp_oh = 4'b0000; exp_val = 32'h0; end
            endcase
            n_cmp++;
            if (rsp_valid !== exp_oh || (exp_oh != 4'b0000 && rsp_val !== exp_val)) begin
                n_bad++; $display("FAIL wrap_rsp: step %0d got %b/%h expected %b/%h", m, rsp_valid, rsp_val, exp_oh, exp_val);
            end
            if (exp_oh != 4'b0000) $display("wrap: rsp %b val %h", rsp_valid, rsp_val);
        end
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++; $display("FAIL wrap_err: got %b expected 0", err);
        end
    endtask

    task automatic test_reset_midflight();
        for (int m = 0; m < 3; m++) begin
            set_op(0, DW'(m + 1), 32'd10);
            req_valid = 4'b0001;
            step();
        end
        req_valid = '0;
        step();
        rst = 1'b1;
        req_valid = 4'b0010;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0000) begin
            n_bad++; $display("FAIL mid_ready_in_reset: got %b expected 0000", req_ready);
        end
        req_valid = '0;
        step();
        rst = 1'b0;
        n_cmp++;
        if ({busy, adder_valid, rsp_valid} !== 6'b0) begin
            n_bad++; $display("FAIL mid_busy: got busy=%b v=%b rsp=%b expected 0", busy, adder_valid, rsp_valid);
        end
        for (int c = 0; c < 12; c++) begin
            step();
            n_cmp++;
            if (rsp_valid !== 4'b0000) begin
                n_bad++; $display("FAIL mid_stale_rsp: step %0d got %b expected 0000", c, rsp_valid);
            end
        end
        set_op(2, 32'd10, 32'd20);
        req_valid = 4'b0100;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0100) begin
            n_bad++; $display("FAIL mid_new_ready: got %b expected 0100", req_ready);
        end
        step();
        req_valid = '0;
        for (int c = 0; c < 8; c++) step();
        n_cmp++;
        if (rsp_valid !== 4'b0100 || rsp_val !== 32'd30) begin
            n_bad++; $display("FAIL mid_new_rsp: got %b/%0d expected 0100/30", rsp_valid, rsp_val);
        end
        $display("midflight: post-reset rsp %b val %0d", rsp_valid, rsp_val);
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++; $display("FAIL mid_err: got %b expected 0", err);
        end
    endtask

    task automatic test_error();
        step();
        inj = 1'b1;
        step();
        inj = 1'b0;
        n_cmp++;
        if (err !== 1'b1 || rsp_valid !== 4'b0000) begin
            n_bad++; $display("FAIL err_set: got err=%b rsp=%b expected 1/0000", err, rsp_valid);
        end
        for (int c = 0; c < 5; c++) step();
        n_cmp++;
        if (err !== 1'b1) begin
            n_bad++; $display("FAIL err_sticky: got %b expected 1", err);
        end
        $display("error: spurious strobe -> err %b", err);
        do_reset();
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++; $display("FAIL err_clear: got %b expected 0", err);
        end
    endtask

    initial begin
        rst = 1'b1;
        inj = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_round_robin();
        test_wrap_carry();
        test_reset_midflight();
        test_error();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
